// File: rtl/hcsr04_pkg.sv
// ---------------------------------------------------------------------------
// hcsr04_pkg: shared state codes, default parameters and helpers. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hcsr04_pkg;

  localparam int unsigned DEF_N_CH           = 2;
  localparam int unsigned DEF_TRIG_CYCLES    = 500;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1500000;
  localparam int unsigned DEF_W              = 24;

  // Encodings double as the db_estado debug code.
  typedef enum logic [3:0] {
    ST_INICIAL       = 4'b0000,
    ST_PREPARACAO    = 4'b0001,
    ST_ENVIA_TRIGGER = 4'b0010,
    ST_ESPERA_ECHO   = 4'b0011,
    ST_MEDIDA        = 4'b0100,
    ST_ARMAZENAMENTO = 4'b0101,
    ST_PROXIMO       = 4'b0110,
    ST_ERRO_TIMEOUT  = 4'b1110,
    ST_FINAL_MEDIDA  = 4'b1111
  } state_t;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hcsr04_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// hcsr04_scan_ctrl_if: control, echo/trigger and result bundle. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hcsr04_scan_ctrl_if #(
  parameter int unsigned N_CH = hcsr04_pkg::DEF_N_CH,
  parameter int unsigned W    = hcsr04_pkg::DEF_W
);
  import hcsr04_pkg::*;

  localparam int unsigned CW = ch_width(N_CH);

  logic            medir;
  logic            continuo;
  logic [N_CH-1:0] echo;
  logic [N_CH-1:0] trigger;
  logic [W-1:0]    largura;
  logic [CW-1:0]   canal;
  logic            timeout;
  logic            pronto;
  logic            ocupado;
  logic [3:0]      db_estado;

  modport master (
    output medir, continuo, echo,
    input  trigger, largura, canal, timeout, pronto, ocupado, db_estado
  );

  modport slave (
    input  medir, continuo, echo,
    output trigger, largura, canal, timeout, pronto, ocupado, db_estado
  );

endinterface

`default_nettype wire

// File: rtl/hcsr04_scan_fd.sv
// ---------------------------------------------------------------------------
// hcsr04_scan_fd: trigger driver, trigger/timeout/width counters, result regs. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hcsr04_scan_fd #(
  parameter int unsigned N_CH           = hcsr04_pkg::DEF_N_CH,
  parameter int unsigned TRIG_CYCLES    = hcsr04_pkg::DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = hcsr04_pkg::DEF_TIMEOUT_CYCLES,
  parameter int unsigned W              = hcsr04_pkg::DEF_W
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    clr_i,
  input  logic                                    trig_en_i,
  input  logic                                    trig_next_i,
  input  logic                                    tmo_en_i,
  input  logic                                    wid_en_i,
  input  logic                                    store_ok_i,
  input  logic                                    store_err_i,
  input  logic [hcsr04_pkg::ch_width(N_CH)-1:0]   ch_i,
  input  logic [N_CH-1:0]                         echo_i,
  output logic                                    trig_done_o,
  output logic                                    tmo_hit_o,
  output logic                                    echo_sel_o,
  output logic [N_CH-1:0]                         trigger_o,
  output logic [W-1:0]                            largura_o,
  output logic [hcsr04_pkg::ch_width(N_CH)-1:0]   canal_o,
  output logic                                    timeout_o
);
  import hcsr04_pkg::*;

  localparam int unsigned CW  = ch_width(N_CH);
  localparam int unsigned TCW = $clog2(TRIG_CYCLES + 1);
  localparam int unsigned OCW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TCW-1:0]  trig_cnt_q;
  logic [OCW-1:0]  tmo_cnt_q;
  logic [W-1:0]    wid_cnt_q;
  logic [N_CH-1:0] trigger_q, trigger_d;
  logic [W-1:0]    largura_q;
  logic [CW-1:0]   canal_q;
  logic            timeout_q;

  // Trigger is registered from the FSM's next state so the pin never glitches.
  assign trigger_d = trig_next_i ? (N_CH'(1) << ch_i) : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      wid_cnt_q  <= '0;
      trigger_q  <= '0;
      largura_q  <= '0;
      canal_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      trigger_q <= trigger_d;
      if (clr_i) begin
        trig_cnt_q <= '0;
        tmo_cnt_q  <= '0;
        wid_cnt_q  <= '0;
      end else begin
        if (trig_en_i) trig_cnt_q <= trig_cnt_q + TCW'(1);
        if (tmo_en_i)  tmo_cnt_q  <= tmo_cnt_q + OCW'(1);
        if (wid_en_i && (wid_cnt_q != '1)) wid_cnt_q <= wid_cnt_q + W'(1);
      end
      if (store_ok_i) begin
        largura_q <= wid_cnt_q;
        canal_q   <= ch_i;
        timeout_q <= 1'b0;
      end else if (store_err_i) begin
        largura_q <= '1;
        canal_q   <= ch_i;
        timeout_q <= 1'b1;
      end
    end
  end

  assign trig_done_o = (trig_cnt_q == TCW'(TRIG_CYCLES - 1));
  assign tmo_hit_o   = (tmo_cnt_q == OCW'(TIMEOUT_CYCLES - 1));
  assign echo_sel_o  = echo_i[ch_i];
  assign trigger_o   = trigger_q;
  assign largura_o   = largura_q;
  assign canal_o     = canal_q;
  assign timeout_o   = timeout_q;

endmodule

`default_nettype wire

// File: rtl/hcsr04_scan_ctrl.sv
// ---------------------------------------------------------------------------
// hcsr04_scan_ctrl: sequential HC-SR04 multi-channel scan FSM. rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hcsr04_scan_ctrl #(
  parameter int unsigned N_CH           = hcsr04_pkg::DEF_N_CH,
  parameter int unsigned TRIG_CYCLES    = hcsr04_pkg::DEF_TRIG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = hcsr04_pkg::DEF_TIMEOUT_CYCLES,
  parameter int unsigned W              = hcsr04_pkg::DEF_W
) (
  input  logic               clock,
  input  logic               reset,
  hcsr04_scan_ctrl_if.slave  bus
);
  import hcsr04_pkg::*;

  localparam int unsigned CW = ch_width(N_CH);

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;

  logic            clr, trig_en, trig_next, tmo_en, wid_en, store_ok, store_err;
  logic            trig_done, tmo_hit, echo_sel;
  logic [N_CH-1:0] trigger_w;
  logic [W-1:0]    largura_w;
  logic [CW-1:0]   canal_w;
  logic            timeout_w;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INICIAL;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    clr       = 1'b0;
    trig_en   = 1'b0;
    tmo_en    = 1'b0;
    wid_en    = 1'b0;
    store_ok  = 1'b0;
    store_err = 1'b0;
    case (state_q)
      ST_INICIAL: begin
        if (bus.medir) begin
          state_d = ST_PREPARACAO;
          ch_d    = '0;
        end
      end
      ST_PREPARACAO: begin
        clr     = 1'b1;
        state_d = ST_ENVIA_TRIGGER;
      end
      ST_ENVIA_TRIGGER: begin
        trig_en = 1'b1;
        if (trig_done) state_d = ST_ESPERA_ECHO;
      end
      // The echo's rising cycle is counted so width equals high cycles seen.
      ST_ESPERA_ECHO: begin
        tmo_en = 1'b1;
        if (tmo_hit) begin
          state_d = ST_ERRO_TIMEOUT;
        end else if (echo_sel) begin
          wid_en  = 1'b1;
          state_d = ST_MEDIDA;
        end
      end
      ST_MEDIDA: begin
        tmo_en = 1'b1;
        if (!echo_sel) begin
          state_d = ST_ARMAZENAMENTO;
        end else if (tmo_hit) begin
          state_d = ST_ERRO_TIMEOUT;
        end else begin
          wid_en = 1'b1;
        end
      end
      ST_ARMAZENAMENTO: begin
        store_ok = 1'b1;
        state_d  = ST_PROXIMO;
      end
      ST_ERRO_TIMEOUT: begin
        store_err = 1'b1;
        state_d   = ST_PROXIMO;
      end
      ST_PROXIMO: begin
        if (ch_q != CW'(N_CH - 1)) begin
          ch_d    = ch_q + CW'(1);
          state_d = ST_PREPARACAO;
        end else if (bus.continuo) begin
          ch_d    = '0;
          state_d = ST_PREPARACAO;
        end else begin
          state_d = ST_FINAL_MEDIDA;
        end
      end
      ST_FINAL_MEDIDA: state_d = ST_INICIAL;
      default:         state_d = ST_INICIAL;
    endcase
  end

  assign trig_next = (state_d == ST_ENVIA_TRIGGER);

  hcsr04_scan_fd #(
    .N_CH           (N_CH),
    .TRIG_CYCLES    (TRIG_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .W              (W)
  ) u_fd (
    .clock       (clock),
    .reset       (reset),
    .clr_i       (clr),
    .trig_en_i   (trig_en),
    .trig_next_i (trig_next),
    .tmo_en_i    (tmo_en),
    .wid_en_i    (wid_en),
    .store_ok_i  (store_ok),
    .store_err_i (store_err),
    .ch_i        (ch_q),
    .echo_i      (bus.echo),
    .trig_done_o (trig_done),
    .tmo_hit_o   (tmo_hit),
    .echo_sel_o  (echo_sel),
    .trigger_o   (trigger_w),
    .largura_o   (largura_w),
    .canal_o     (canal_w),
    .timeout_o   (timeout_w)
  );

  assign bus.trigger   = trigger_w;
  assign bus.largura   = largura_w;
  assign bus.canal     = canal_w;
  assign bus.timeout   = timeout_w;
  assign bus.pronto    = (state_q == ST_PROXIMO);
  assign bus.ocupado   = (state_q != ST_INICIAL);
  assign bus.db_estado = state_q;

endmodule

`default_nettype wire

// File: doc/hcsr04_scan_ctrl.md
HCSR04_SCAN_CTRL -- requirements
Module: hcsr04_scan_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  N_CH, 2, number of HC-SR04 sensor channels (1..8)
  TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz)
  TIMEOUT_CYCLES, 1500000, echo timeout in clocks (30 ms), measured from trigger end
  W, 24, echo width counter / result width
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clock  in  1  system clock, rising edge
  reset  in  1  reset, asynchronous, active-high
  medir  in  1  start request, level-sampled in inicial
  continuo  in  1  1 = rescan all channels forever; 0 = one scan per medir
  echo  in  N_CH  echo inputs, already synchronised externally
  trigger  out  N_CH  one-hot trigger outputs
  largura  out  W  last stored echo width in clocks
  canal  out  clog2(N_CH) (min 1)  channel of last stored result
  timeout  out  1  last stored result timed out
  pronto  out  1  one-cycle strobe: largura/canal/timeout valid
  ocupado  out  1  high whenever state is not inicial
  db_estado  out  4  debug state code

Function
REQ-003 The FSM SHALL have states and db_estado codes: inicial 0000, preparacao 0001, envia_trigger 0010, espera_echo 0011, medida 0100, armazenamento 0101, proximo 0110, erro_timeout 1110, final_medida 1111.
REQ-004 inicial -> preparacao when medir=1, else stay; channel index SHALL be cleared to 0 on this transition.
REQ-005 preparacao SHALL last exactly 1 cycle, clear trigger, timeout and width counters, then go to envia_trigger.
REQ-006 envia_trigger SHALL drive trigger[ch]=1 (all other bits 0) for exactly TRIG_CYCLES cycles, then go to espera_echo.
REQ-007 espera_echo -> medida on first cycle with echo[ch]=1; -> erro_timeout when timeout counter reaches TIMEOUT_CYCLES-1.
REQ-008 medida SHALL increment the width counter each cycle while echo[ch]=1, saturating at 2^W-1; on echo[ch]=0 -> armazenamento; on timeout -> erro_timeout.
REQ-009 The timeout counter SHALL run continuously through espera_echo and medida; echo on channels other than ch SHALL be ignored.
REQ-010 armazenamento SHALL register largura=width counter, canal=ch, timeout=0; erro_timeout SHALL register largura=all ones, canal=ch, timeout=1; both -> proximo.
REQ-011 pronto SHALL be 1 exactly in the cycle after armazenamento or erro_timeout (i.e. while in proximo), with outputs already updated.
REQ-012 proximo: if ch<N_CH-1, increment ch -> preparacao; else if continuo=1, ch=0 -> preparacao; else -> final_medida.
REQ-013 final_medida SHALL last 1 cycle then -> inicial; medir held high SHALL start a new scan immediately.
REQ-014 Dropping continuo mid-scan SHALL finish the current scan then stop; medir outside inicial SHALL be ignored.
REQ-015 Unreachable state encodings SHALL go to inicial, db_estado 1110 only via erro_timeout.

Reset
REQ-016 On reset: state inicial, ch=0, all counters 0, trigger=0, largura=0, canal=0, timeout=0, pronto=0, ocupado=0, db_estado=0000; reset mid-trigger SHALL drop trigger in the same cycle asynchronously.

Structure
REQ-017 State encodings and default parameter values SHALL live in shared package hcsr04_pkg.
REQ-018 Datapath (trigger, timeout, width counters, result registers) SHALL be sub-module hcsr04_scan_fd; the top holds the FSM.

Verification
REQ-019 N_CH=2, TRIG_CYCLES=5, TIMEOUT_CYCLES=100, continuo=0: medir pulse, echo[0] high 20 cycles after 3-cycle delay -> trigger[0] high 5 cycles, pronto with largura=20, canal=0, timeout=0; then channel 1.
REQ-020 Echo[1] never rises -> pronto with canal=1, largura=all ones, timeout=1, then final_medida, inicial.
REQ-021 W=4, echo high 40 cycles -> largura=15 (saturated), timeout=0.
REQ-022 continuo=1 -> channel order 0,1,0,1 with ocupado constantly high; continuo cleared during ch=0 -> scan completes at ch=1, returns to inicial.
REQ-023 reset asserted during envia_trigger -> trigger and all outputs zero immediately; echo asserted on non-selected channel -> no effect on largura.
